// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared sequencer states, IR fetch-mode codes and opcode defaults
//   FETCH_SINGLE_STEP_EN adds the STEP state used by the single-step build.
package fetch_ctrl_pkg;
   typedef enum logic [2:0] {
      S_F1,
      S_DEC,
      S_F2,
      S_EXEC,
      S_HALT
`ifdef FETCH_SINGLE_STEP_EN
      , S_STEP
`endif
   } state_e;
   localparam logic [1:0] FM_HOLD = 2'b00;
   localparam logic [1:0] FM_OP1 = 2'b01;
   localparam logic [1:0] FM_OP2 = 2'b10;
   localparam logic [2:0] HALT_OP_DEF = 3'b111;
   localparam logic [7:0] TWO_BYTE_DEF = 8'b0011_1110;
endpackage

// File: rtl/fetch_ctrl_pc_counter.sv
// fetch_ctrl_pc_counter: program counter with jump load, increment and sync reset
//   clk_i/rst_i  clock, synchronous active-high reset to RESET_PC
//   inc_i        advance PC by one (wraps modulo 2^PC_W)
//   ld_i         load ld_val_i (takes priority over inc_i)
//   pc_o         current PC
module fetch_ctrl_pc_counter #(
   parameter int unsigned PC_W = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            inc_i,
   input  logic            ld_i,
   input  logic [PC_W-1:0] ld_val_i,
   output logic [PC_W-1:0] pc_o
);
   logic [PC_W-1:0] pc_q, pc_d;
   always_comb pc_d = ld_i ? ld_val_i : inc_i ? pc_q + PC_W'(1) : pc_q;
   always_ff @(posedge clk_i) pc_q <= rst_i ? RESET_PC : pc_d;
   assign pc_o = pc_q;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer (ROM req/ack, IR load, execute handshake)
//   FETCH_SINGLE_STEP_EN: adds i_step; after each instruction waits in STEP for i_step.
//   i_clk/i_rst                     clock, synchronous active-high reset
//   o_mem_addr/o_mem_rd/i_mem_ack   ROM read handshake, address = PC
//   o_fetch_mode/i_ins_func         IR load control (01 opcode, 10 operand) and decoded opcode
//   o_exec_start/i_exec_done        execute handshake; i_jmp_en/i_jmp_addr branch on done
//   o_pc/o_halted                   current PC, halted on HALT_OP
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned PC_W = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [7:0] TWO_BYTE = TWO_BYTE_DEF,
   parameter logic [2:0] HALT_OP = HALT_OP_DEF
) (
   input  logic            i_clk,
   input  logic            i_rst,
   output logic [PC_W-1:0] o_mem_addr,
   output logic            o_mem_rd,
   input  logic            i_mem_ack,
   output logic [1:0]      o_fetch_mode,
   input  logic [2:0]      i_ins_func,
   output logic            o_exec_start,
   input  logic            i_exec_done,
   input  logic            i_jmp_en,
   input  logic [PC_W-1:0] i_jmp_addr,
`ifdef FETCH_SINGLE_STEP_EN
   input  logic            i_step,
`endif
   output logic [PC_W-1:0] o_pc,
   output logic            o_halted
);
   state_e state_q, state_d;
   logic started_q, started_d, pc_inc, pc_ld;
   logic [PC_W-1:0] pc;
   fetch_ctrl_pc_counter #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
      .clk_i(i_clk),
      .rst_i(i_rst),
      .inc_i(pc_inc),
      .ld_i(pc_ld),
      .ld_val_i(i_jmp_addr),
      .pc_o(pc)
   );
   always_ff @(posedge i_clk) begin
      state_q <= i_rst ? S_F1 : state_d;
      started_q <= i_rst ? 1'b0 : started_d;
   end
   always_comb begin
      state_d = state_q;
      started_d = started_q;
      pc_inc = 1'b0;
      pc_ld = 1'b0;
      o_mem_rd = 1'b0;
      o_fetch_mode = FM_HOLD;
      o_exec_start = 1'b0;
      o_halted = 1'b0;
      case (state_q)
         S_F1, S_F2: begin
            o_mem_rd = 1'b1;
            if (i_mem_ack) begin
               o_fetch_mode = state_q == S_F1 ? FM_OP1 : FM_OP2;
               pc_inc = 1'b1;
               state_d = state_q == S_F1 ? S_DEC : S_EXEC;
            end
         end
         S_DEC: state_d = i_ins_func == HALT_OP ? S_HALT : TWO_BYTE[i_ins_func] ? S_F2 : S_EXEC;
         S_EXEC: begin
            // started_q marks that the start pulse was already issued for this instruction
            o_exec_start = !started_q;
            started_d = !i_exec_done;
            if (i_exec_done) begin
               pc_ld = i_jmp_en;
`ifdef FETCH_SINGLE_STEP_EN
               state_d = S_STEP;
`else
               state_d = S_F1;
`endif
            end
         end
         S_HALT: o_halted = 1'b1;
`ifdef FETCH_SINGLE_STEP_EN
         S_STEP: state_d = i_step ? S_F1 : S_STEP;
`endif
         default: state_d = S_F1;
      endcase
      // outputs stay quiet for as long as reset is held, abandoning any open request
      if (i_rst) begin
         o_mem_rd = 1'b0;
         o_fetch_mode = FM_HOLD;
         o_exec_start = 1'b0;
         o_halted = 1'b0;
      end
   end
   assign o_mem_addr = pc;
   assign o_pc = pc;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl with ROM, IR and execute models
module tb_fetch_ctrl;
   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic [7:0] o_mem_addr;
   logic       o_mem_rd;
   logic       i_mem_ack;
   logic [1:0] o_fetch_mode;
   logic [2:0] i_ins_func;
   logic       o_exec_start;
   logic       i_exec_done;
   logic       i_jmp_en = 1'b0;
   logic [7:0] i_jmp_addr = 8'h00;
   logic [7:0] o_pc;
   logic       o_halted;
`ifdef FETCH_SINGLE_STEP_EN
   logic       i_step = 1'b0;
`endif
   logic [7:0] rom [256];
   logic [2:0] ir_q = 3'b000;
   int         wait_n = 0;
   int         wcnt = 0;
   int         n_start = 0;
   int         snap = 0;
   logic       auto_done = 1'b1;
   logic       man_done = 1'b0;
   int         n_chk = 0;
   int         n_err = 0;

   fetch_ctrl dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .o_mem_addr(o_mem_addr),
      .o_mem_rd(o_mem_rd),
      .i_mem_ack(i_mem_ack),
      .o_fetch_mode(o_fetch_mode),
      .i_ins_func(i_ins_func),
      .o_exec_start(o_exec_start),
      .i_exec_done(i_exec_done),
      .i_jmp_en(i_jmp_en),
      .i_jmp_addr(i_jmp_addr),
`ifdef FETCH_SINGLE_STEP_EN
      .i_step(i_step),
`endif
      .o_pc(o_pc),
      .o_halted(o_halted)
   );

   always #5 i_clk = ~i_clk;

   assign i_mem_ack = o_mem_rd && (wcnt == wait_n);
   assign i_ins_func = ir_q;
   assign i_exec_done = auto_done ? o_exec_start : man_done;

   always @(posedge i_clk) begin
      wcnt <= (o_mem_rd && !i_mem_ack) ? wcnt + 1 : 0;
      if (o_fetch_mode == 2'b01) ir_q <= rom[o_mem_addr][7:5];
      if (o_exec_start) n_start <= n_start + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic finish_exec();
      tick();
      man_done = 1'b0;
      i_jmp_en = 1'b0;
`ifdef FETCH_SINGLE_STEP_EN
      check("step_hold", 32'(o_mem_rd), 0);
      i_step = 1'b1;
      tick();
      i_step = 1'b0;
`endif
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      // 1: one-byte instruction, zero-wait ROM, done same cycle
      rom[8'h00] = 8'h05;
      tick();
      tick();
      check("rst_rd", 32'(o_mem_rd), 0);
      check("rst_fm", 32'(o_fetch_mode), 0);
      check("rst_start", 32'(o_exec_start), 0);
      check("rst_halted", 32'(o_halted), 0);
      check("rst_pc", 32'(o_pc), 32'h00);
      i_rst = 1'b0;
      #1;
      check("t1_rd", 32'(o_mem_rd), 1);
      check("t1_addr", 32'(o_mem_addr), 32'h00);
      check("t1_fm", 32'(o_fetch_mode), 1);
      tick();
      check("t1_dec_rd", 32'(o_mem_rd), 0);
      check("t1_dec_pc", 32'(o_pc), 32'h01);
      tick();
      check("t1_start", 32'(o_exec_start), 1);
      finish_exec();
      check("t1_next_rd", 32'(o_mem_rd), 1);
      check("t1_next_addr", 32'(o_mem_addr), 32'h01);
      // 2: two-byte instruction, two wait cycles per read
      i_rst = 1'b1;
      rom[8'h00] = 8'h21;
      rom[8'h01] = 8'h77;
      wait_n = 2;
      tick();
      snap = n_start;
      i_rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         check("t2_op_addr", 32'(o_mem_addr), 32'h00);
         check("t2_op_fm", 32'(o_fetch_mode), k == 2 ? 1 : 0);
         if (k < 2) tick();
      end
      tick();
      check("t2_dec_rd", 32'(o_mem_rd), 0);
      tick();
      for (int k = 0; k < 3; k++) begin
         check("t2_arg_addr", 32'(o_mem_addr), 32'h01);
         check("t2_arg_fm", 32'(o_fetch_mode), k == 2 ? 2 : 0);
         if (k < 2) tick();
      end
      tick();
      check("t2_start", 32'(o_exec_start), 1);
      finish_exec();
      check("t2_start_once", 32'(n_start - snap), 1);
      check("t2_next_addr", 32'(o_mem_addr), 32'h02);
      // 3: jump on done, jump inputs ignored in F1/DEC
      i_rst = 1'b1;
      rom[8'h00] = 8'h05;
      rom[8'h40] = 8'h05;
      wait_n = 0;
      auto_done = 1'b0;
      tick();
      i_jmp_en = 1'b1;
      i_jmp_addr = 8'h80;
      i_rst = 1'b0;
      #1;
      check("t3_addr", 32'(o_mem_addr), 32'h00);
      tick();
      tick();
      check("t3_start", 32'(o_exec_start), 1);
      i_jmp_en = 1'b0;
      tick();
      check("t3_start_once", 32'(o_exec_start), 0);
      check("t3_pc_nojmp", 32'(o_pc), 32'h01);
      man_done = 1'b1;
      i_jmp_en = 1'b1;
      i_jmp_addr = 8'h40;
      #1;
      finish_exec();
      check("t3_jmp_addr", 32'(o_mem_addr), 32'h40);
      check("t3_jmp_rd", 32'(o_mem_rd), 1);
      // 4: wrap between opcode at FF and operand at 00
      rom[8'hFF] = 8'h41;
      tick();
      tick();
      man_done = 1'b1;
      i_jmp_en = 1'b1;
      i_jmp_addr = 8'hFF;
      #1;
      finish_exec();
      check("t4_op_addr", 32'(o_mem_addr), 32'hFF);
      tick();
      tick();
      check("t4_arg_addr", 32'(o_mem_addr), 32'h00);
      check("t4_arg_fm", 32'(o_fetch_mode), 2);
      tick();
      man_done = 1'b1;
      #1;
      finish_exec();
      check("t4_next_addr", 32'(o_mem_addr), 32'h01);
      // 5: halt opcode, then reset recovers
      rom[8'h01] = 8'hE0;
      tick();
      tick();
      check("t5_halted", 32'(o_halted), 1);
      for (int k = 0; k < 20; k++) begin
         check("t5_halt_rd", 32'(o_mem_rd), 0);
         tick();
      end
      check("t5_still_halted", 32'(o_halted), 1);
      i_rst = 1'b1;
      tick();
      check("t5_rst_pc", 32'(o_pc), 32'h00);
      check("t5_rst_halted", 32'(o_halted), 0);
      i_rst = 1'b0;
      #1;
      check("t5_resume_rd", 32'(o_mem_rd), 1);
      check("t5_resume_halted", 32'(o_halted), 0);
      // 6: reset during operand wait abandons the request
      i_rst = 1'b1;
      rom[8'h00] = 8'h21;
      wait_n = 3;
      tick();
      i_rst = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         check("t6_op_fm", 32'(o_fetch_mode), k == 3 ? 1 : 0);
         if (k < 3) tick();
      end
      tick();
      tick();
      check("t6_f2_rd", 32'(o_mem_rd), 1);
      check("t6_f2_addr", 32'(o_mem_addr), 32'h01);
      tick();
      i_rst = 1'b1;
      tick();
      check("t6_rst_rd", 32'(o_mem_rd), 0);
      check("t6_rst_fm", 32'(o_fetch_mode), 0);
      check("t6_rst_pc", 32'(o_pc), 32'h00);
      i_rst = 1'b0;
      #1;
      check("t6_restart_rd", 32'(o_mem_rd), 1);
      check("t6_restart_addr", 32'(o_mem_addr), 32'h00);
`ifdef FETCH_SINGLE_STEP_EN
      // single step: no request after done until i_step
      i_rst = 1'b1;
      rom[8'h00] = 8'h05;
      wait_n = 0;
      tick();
      i_rst = 1'b0;
      #1;
      tick();
      tick();
      man_done = 1'b1;
      #1;
      tick();
      man_done = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("ss_wait_rd", 32'(o_mem_rd), 0);
         tick();
      end
      i_step = 1'b1;
      #1;
      check("ss_step_rd", 32'(o_mem_rd), 0);
      tick();
      i_step = 1'b0;
      #1;
      check("ss_go_rd", 32'(o_mem_rd), 1);
      check("ss_go_addr", 32'(o_mem_addr), 32'h01);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
